// File: rtl/mario_pkg.sv
// mario_pkg: shared block types, level ROM entry layout and the horizontal wrap helper.
package mario_pkg;
   typedef logic [9:0] coord_t;
   typedef logic [3:0] block_id_t;
   localparam block_id_t BLOCK_ID_EMPTY = '0;
   typedef struct packed {
      block_id_t id;
      coord_t    x;
      coord_t    y;
   } level_entry_t;
   function automatic coord_t wrap_left(coord_t x, logic [3:0] dx, int span);
      logic [10:0] d, r;
      d = {7'd0, dx};
      r = ({1'b0, x} >= d) ? {1'b0, x} - d : {1'b0, x} + 11'(span) - d;
      return r[9:0];
   endfunction
endpackage

// File: rtl/slot_y_shadow.sv
// slot_y_shadow: per-slot copy of Y, since the slot bank only reads back X and id.
module slot_y_shadow
   import mario_pkg::*;
#(
   parameter int NUM_SLOTS = 16,
   localparam int SW = $clog2(NUM_SLOTS)
) (
   input  logic          Clk,
   input  logic          we,
   input  logic [SW-1:0] waddr,
   input  logic [9:0]    wdata,
   input  logic [SW-1:0] raddr,
   output logic [9:0]    rdata
);
   coord_t mem [NUM_SLOTS];
   always_ff @(posedge Clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/block_slot_sequencer.sv
// block_slot_sequencer: loads a level block table into all slots and scrolls occupied slots left with wrap.
module block_slot_sequencer
   import mario_pkg::*;
#(
   parameter int NUM_SLOTS = 16,
   parameter int ROM_AW = 8,
   parameter int SCREEN_W = 640,
   localparam int SW = $clog2(NUM_SLOTS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              load_start,
   input  logic [ROM_AW-1:0] level_base,
   input  logic              scroll_step,
   input  logic [3:0]        scroll_dx,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   input  logic [9:0]        sel_Xcoord,
   input  logic [3:0]        sel_block_id,
   output logic [SW-1:0]     slot_sel,
   output logic              change_coords,
   output logic              change_id,
   output logic [9:0]        new_Xcoord,
   output logic [9:0]        new_Ycoord,
   output logic [3:0]        new_block_id,
   output logic              busy,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, LD_ADDR, LD_WR, SC_RD, SC_WR, FINISH} state_t;
   state_t            state;
   logic [SW-1:0]     i, i_nx;
   logic [ROM_AW-1:0] base;
   logic [3:0]        dx, pend_dx;
   logic              pending, last;
   level_entry_t      ent;
   logic [9:0]        shadow_y;
   assign ent  = level_entry_t'(rom_data);
   assign i_nx = i + SW'(1);
   assign last = i == SW'(NUM_SLOTS - 1);
   slot_y_shadow #(.NUM_SLOTS(NUM_SLOTS)) u_shadow (
      .Clk(Clk), .we(state == LD_WR), .waddr(i), .wdata(ent.y), .raddr(i), .rdata(shadow_y)
   );
   // ROM data is only valid in LD_WR, so load strobes become visible the cycle after it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         i <= '0;
         base <= '0;
         dx <= '0;
         pend_dx <= '0;
         pending <= 1'b0;
         rom_addr <= '0;
         slot_sel <= '0;
         change_coords <= 1'b0;
         change_id <= 1'b0;
         new_Xcoord <= '0;
         new_Ycoord <= '0;
         new_block_id <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         change_coords <= 1'b0;
         change_id <= 1'b0;
         done <= 1'b0;
         if (state != IDLE && scroll_step) begin
            pending <= 1'b1;
            pend_dx <= scroll_dx;
         end
         case (state)
            IDLE:
               if (load_start) begin
                  base <= level_base;
                  rom_addr <= level_base;
                  i <= '0;
                  busy <= 1'b1;
                  state <= LD_ADDR;
                  if (scroll_step) begin
                     pending <= 1'b1;
                     pend_dx <= scroll_dx;
                  end
               end else if (scroll_step || pending) begin
                  dx <= scroll_step ? scroll_dx : pend_dx;
                  pending <= 1'b0;
                  i <= '0;
                  slot_sel <= '0;
                  busy <= 1'b1;
                  state <= SC_RD;
               end
            LD_ADDR: state <= LD_WR;
            LD_WR: begin
               slot_sel <= i;
               change_coords <= 1'b1;
               change_id <= 1'b1;
               new_Xcoord <= ent.x;
               new_Ycoord <= ent.y;
               new_block_id <= ent.id;
               if (last) begin
                  done <= 1'b1;
                  state <= FINISH;
               end else begin
                  i <= i_nx;
                  rom_addr <= base + ROM_AW'(i_nx);
                  state <= LD_ADDR;
               end
            end
            SC_RD: begin
               if (sel_block_id != BLOCK_ID_EMPTY) begin
                  change_coords <= 1'b1;
                  new_Xcoord <= wrap_left(sel_Xcoord, dx, SCREEN_W);
                  new_Ycoord <= shadow_y;
               end
               state <= SC_WR;
            end
            SC_WR:
               if (last) begin
                  done <= 1'b1;
                  state <= FINISH;
               end else begin
                  i <= i_nx;
                  slot_sel <= i_nx;
                  state <= SC_RD;
               end
            FINISH: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_slot_sequencer.sv
// tb_block_slot_sequencer: ROM and slot-bank environment with a slot-level reference model of loads and scrolls.
module tb_block_slot_sequencer;
   import mario_pkg::*;
   localparam int N = 16;
   logic Clk = 0, Reset = 1, load_start = 0, scroll_step = 0;
   logic [7:0] level_base = 0, rom_addr;
   logic [3:0] scroll_dx = 0, sel_block_id, new_block_id, slot_sel;
   logic [23:0] rom_data;
   logic [9:0] sel_Xcoord, new_Xcoord, new_Ycoord;
   logic change_coords, change_id, busy, done;
   logic [23:0] rom [256];
   logic [9:0] sx [N], sy [N];
   logic [3:0] sid [N];
   int wr_cnt [N];
   int done_cnt;
   logic clr = 0, poke = 0;
   logic [3:0] poke_slot = 0, poke_id = 0;
   logic [9:0] poke_x = 0;
   int ex [N], ey [N], eid [N];
   int checks = 0, errors = 0;
   logic [7:0] addrs [$];
   typedef struct { int x; int id; int dx; int exp_x; int exp_wr; } vec_t;
   vec_t tbl [10];

   always #5 Clk = ~Clk;

   block_slot_sequencer dut (
      .Clk(Clk), .Reset(Reset), .load_start(load_start), .level_base(level_base),
      .scroll_step(scroll_step), .scroll_dx(scroll_dx), .rom_addr(rom_addr), .rom_data(rom_data),
      .sel_Xcoord(sel_Xcoord), .sel_block_id(sel_block_id), .slot_sel(slot_sel),
      .change_coords(change_coords), .change_id(change_id), .new_Xcoord(new_Xcoord),
      .new_Ycoord(new_Ycoord), .new_block_id(new_block_id), .busy(busy), .done(done)
   );

   assign sel_Xcoord = sx[slot_sel];
   assign sel_block_id = sid[slot_sel];

   always @(posedge Clk) begin
      rom_data <= rom[rom_addr];
      if (clr) begin
         done_cnt <= 0;
         foreach (wr_cnt[k]) wr_cnt[k] <= 0;
      end else begin
         if (done) done_cnt <= done_cnt + 1;
         if (change_coords) wr_cnt[slot_sel] <= wr_cnt[slot_sel] + 1;
      end
      if (change_coords) begin
         sx[slot_sel] <= new_Xcoord;
         sy[slot_sel] <= new_Ycoord;
      end
      if (change_id) sid[slot_sel] <= new_block_id;
      if (poke) begin
         sx[poke_slot] <= poke_x;
         sid[poke_slot] <= poke_id;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic start(input logic ld, input logic [7:0] b, input logic sc, input logic [3:0] d);
      @(negedge Clk);
      load_start = ld; level_base = b; scroll_step = sc; scroll_dx = d;
      @(posedge Clk); #1;
      load_start = 0; scroll_step = 0;
   endtask

   task automatic do_clr();
      @(negedge Clk); clr = 1;
      @(posedge Clk); #1; clr = 0;
   endtask

   task automatic do_poke(input int k, input int x, input int id);
      @(negedge Clk);
      poke = 1; poke_slot = 4'(k); poke_x = 10'(x); poke_id = 4'(id);
      @(posedge Clk); #1; poke = 0;
      ex[k] = x; eid[k] = id;
   endtask

   task automatic wait_done(input string nm, input bit chk_busy, output int cyc);
      int lo;
      lo = 0; cyc = 0;
      do begin
         @(negedge Clk);
         cyc++;
         if (!busy) lo++;
         if (addrs.size() == 0 || addrs[$] != rom_addr) addrs.push_back(rom_addr);
      end while (!done && cyc < 200);
      check({nm, " done seen"}, done, 1);
      if (chk_busy) check({nm, " busy held"}, lo, 0);
      @(negedge Clk);
      check({nm, " done one cycle"}, done, 0);
   endtask

   function automatic void model_load(input int b);
      logic [23:0] e;
      for (int k = 0; k < N; k++) begin
         e = rom[(b + k) % 256];
         eid[k] = e[23:20]; ex[k] = e[19:10]; ey[k] = e[9:0];
      end
   endfunction

   function automatic void model_scroll(input int d, input int upto);
      for (int k = 0; k < upto; k++)
         if (eid[k] != 0) ex[k] = (ex[k] >= d) ? ex[k] - d : ex[k] + 640 - d;
   endfunction

   task automatic compare_slots(input string nm);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s slot%0d x", nm, k), sx[k], ex[k]);
         check($sformatf("%s slot%0d y", nm, k), sy[k], ey[k]);
         check($sformatf("%s slot%0d id", nm, k), sid[k], eid[k]);
      end
   endtask

   task automatic check_wr(input string nm, input int occ, input int emp);
      for (int k = 0; k < N; k++)
         check($sformatf("%s writes slot%0d", nm, k), wr_cnt[k], eid[k] != 0 ? occ : emp);
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, " outputs"}, {rom_addr, slot_sel, change_coords, change_id, new_Xcoord,
                               new_Ycoord, new_block_id, busy, done}, 0);
   endtask

   initial begin
      int cyc, d1, d2, d3, inj;
      logic [7:0] b;
      int k;
      for (int a = 0; a < 256; a++) begin
         k = (a - 16) & 255;
         rom[a] = {4'(k), 10'(10 * k), 10'(20 * k)};
      end
      repeat (3) @(negedge Clk);
      check_idle_outputs("reset");
      Reset = 0;

      // basic load with known done timing
      do_clr();
      start(1, 8'h10, 0, 0);
      wait_done("t1", 1, cyc);
      check("t1 done cycle", cyc, 2 * N + 1);
      check("t1 done count", done_cnt, 1);
      model_load(8'h10);
      compare_slots("t1");
      check("t1 slot5 x", sx[5], 50);
      check_wr("t1", 1, 1);

      // base near the top of the ROM wraps the address
      do_clr();
      addrs.delete();
      start(1, 8'hF8, 0, 0);
      wait_done("t2", 1, cyc);
      check("t2 addr count", addrs.size(), N);
      for (int j = 0; j < N && j < addrs.size(); j++)
         check($sformatf("t2 rom_addr%0d", j), addrs[j], (8'hF8 + j) & 8'hFF);
      model_load(8'hF8);
      compare_slots("t2");
      check_wr("t2", 1, 1);

      // first scroll, empty slot 0 untouched
      start(1, 8'h10, 0, 0);
      wait_done("t3 load", 1, cyc);
      model_load(8'h10);
      do_poke(3, 100, 3);
      do_clr();
      start(0, 0, 1, 4);
      wait_done("t3", 1, cyc);
      model_scroll(4, N);
      check("t3 slot3 x", sx[3], 96);
      check("t3 slot3 y", sy[3], 60);
      check("t3 slot0 writes", wr_cnt[0], 0);
      compare_slots("t3");
      check_wr("t3", 1, 0);

      // wrap-left vectors applied to slot 5
      tbl[0] = '{100, 3, 4, 96, 1};
      tbl[1] = '{2, 1, 5, 637, 1};
      tbl[2] = '{5, 1, 5, 0, 1};
      tbl[3] = '{0, 2, 0, 0, 1};
      tbl[4] = '{0, 2, 15, 625, 1};
      tbl[5] = '{1023, 4, 15, 1008, 1};
      tbl[6] = '{14, 5, 15, 639, 1};
      tbl[7] = '{500, 0, 7, 500, 0};
      tbl[8] = '{639, 9, 1, 638, 1};
      tbl[9] = '{3, 15, 9, 634, 1};
      foreach (tbl[v]) begin
         do_poke(5, tbl[v].x, tbl[v].id);
         do_clr();
         start(0, 0, 1, 4'(tbl[v].dx));
         wait_done($sformatf("vec%0d", v), 1, cyc);
         model_scroll(tbl[v].dx, N);
         check($sformatf("vec%0d x", v), sx[5], tbl[v].exp_x);
         check($sformatf("vec%0d writes", v), wr_cnt[5], tbl[v].exp_wr);
      end
      compare_slots("vec");

      // simultaneous load+scroll, and a stray load mid-load
      do_clr();
      start(1, 8'h20, 1, 3);
      repeat (9) @(negedge Clk);
      start(1, 8'h40, 0, 0);
      wait_done("t5 load", 1, cyc);
      model_load(8'h20);
      wait_done("t5 scroll", 0, cyc);
      model_scroll(3, N);
      compare_slots("t5");
      check("t5 done count", done_cnt, 2);

      // reset during the write of slot 7
      start(1, 8'h11, 0, 0);
      wait_done("t6 load", 1, cyc);
      model_load(8'h11);
      do_clr();
      start(0, 0, 1, 6);
      cyc = 0;
      do begin @(negedge Clk); cyc++; end while (!(change_coords && slot_sel == 4'd7) && cyc < 100);
      check("t6 reached slot7", change_coords && slot_sel == 4'd7, 1);
      Reset = 1;
      @(posedge Clk); #1;
      check_idle_outputs("t6 after reset");
      repeat (2) @(negedge Clk);
      Reset = 0;
      repeat (3) @(negedge Clk);
      model_scroll(6, 8);
      compare_slots("t6");
      check("t6 no done", done_cnt, 0);
      check_idle_outputs("t6 idle");

      // randomized loads and scrolls with pending steps
      for (int a = 0; a < 256; a++) begin
         rom[a] = 24'($urandom);
         if ($urandom_range(3) == 0) rom[a][23:20] = 4'd0;
      end
      for (int r = 0; r < 6; r++) begin
         b = 8'($urandom);
         d1 = $urandom_range(15); d2 = $urandom_range(15); d3 = $urandom_range(15);
         inj = $urandom_range(2);
         do_clr();
         start(1, b, 0, 0);
         wait_done("rnd load", 1, cyc);
         model_load(b);
         compare_slots($sformatf("rnd%0d load", r));
         do_clr();
         start(0, 0, 1, 4'(d1));
         if (inj > 0) begin
            repeat (2 + $urandom_range(10)) @(negedge Clk);
            start(0, 0, 1, 4'(d2));
         end
         if (inj > 1) begin
            repeat (2 + $urandom_range(10)) @(negedge Clk);
            start(0, 0, 1, 4'(d3));
         end
         wait_done("rnd sc1", 1, cyc);
         model_scroll(d1, N);
         if (inj > 0) begin
            wait_done("rnd sc2", 0, cyc);
            model_scroll(inj > 1 ? d3 : d2, N);
         end
         compare_slots($sformatf("rnd%0d scroll", r));
         check($sformatf("rnd%0d done count", r), done_cnt, inj > 0 ? 2 : 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
